// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings and packed control-bundle types for the
// pipeline control slice.
//   ALUOp encodings, forwarding-select encodings, per-stage control
//   bundles (EX, MEM, WB) and their all-zero bubble constants.
package ctrl_pkg;

  localparam logic [1:0] ALUOP_R = 2'b00;
  localparam logic [1:0] ALUOP_I = 2'b01;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       branch;
  } ex_ctrl_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
  } mem_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  localparam ex_ctrl_t  EX_CTRL_ZERO  = '{alu_op: 2'b00, alu_src: 1'b0, branch: 1'b0};
  localparam mem_ctrl_t MEM_CTRL_ZERO = '{mem_read: 1'b0, mem_write: 1'b0};
  localparam wb_ctrl_t  WB_CTRL_ZERO  = '{reg_write: 1'b0, mem_to_reg: 1'b0};

endpackage

// File: rtl/ctrl_stage_reg.sv
// ctrl_stage_reg: width-parameterised pipeline stage register.
//   clk_i     clock
//   rst_i     async active-high reset, clears q_o
//   en_i      load enable
//   bubble_i  synchronous clear (wins over en_i)
//   d_i       next contents
//   q_o       registered contents
module ctrl_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         bubble_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else if (bubble_i) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline: carries the decoder control bundle and register addresses
// through ID/EX, EX/MEM and MEM/WB, detects load-use hazards and computes
// EX-stage forwarding selects.
//   Inputs : decoder control bits and rs1/rs2/rd of the instruction in ID.
//   Outputs: No_Op_o/Stall_o/PCWrite_o hazard controls, EX/MEM/WB stage
//            controls and rd, ForwardA_o/ForwardB_o, saturating stall count.
module ctrl_pipeline
  import ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        ALUOp_i,
  input  logic              ALUSrc_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              Branch_i,
  input  logic [REG_AW-1:0] RS1addr_i,
  input  logic [REG_AW-1:0] RS2addr_i,
  input  logic [REG_AW-1:0] RDaddr_i,
  output logic              No_Op_o,
  output logic              Stall_o,
  output logic              PCWrite_o,
  output logic [1:0]        EX_ALUOp_o,
  output logic              EX_ALUSrc_o,
  output logic [REG_AW-1:0] EX_RDaddr_o,
  output logic [1:0]        ForwardA_o,
  output logic [1:0]        ForwardB_o,
  output logic              MEM_RegWrite_o,
  output logic              MEM_MemtoReg_o,
  output logic              MEM_MemRead_o,
  output logic              MEM_MemWrite_o,
  output logic [REG_AW-1:0] MEM_RDaddr_o,
  output logic              WB_RegWrite_o,
  output logic              WB_MemtoReg_o,
  output logic [REG_AW-1:0] WB_RDaddr_o,
  output logic [CNT_W-1:0]  stall_count_o
);

  typedef struct packed {
    ex_ctrl_t          ex;
    mem_ctrl_t         mem;
    wb_ctrl_t          wb;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
  } idex_t;

  typedef struct packed {
    mem_ctrl_t         mem;
    wb_ctrl_t          wb;
    logic [REG_AW-1:0] rd;
  } exmem_t;

  typedef struct packed {
    wb_ctrl_t          wb;
    logic [REG_AW-1:0] rd;
  } memwb_t;

  idex_t  idex_d,  idex_q;
  exmem_t exmem_d, exmem_q;
  memwb_t memwb_d, memwb_q;

  logic             hz;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  // Load-use hazard against the load currently in EX; x0 never hazards.
  assign hz = idex_q.mem.mem_read && (idex_q.rd != '0) &&
              ((idex_q.rd == RS1addr_i) || (idex_q.rd == RS2addr_i));

  assign No_Op_o   = hz;
  assign Stall_o   = hz;
  assign PCWrite_o = ~hz;

  always_comb begin
    idex_d            = '0;
    idex_d.ex.alu_op  = ALUOp_i;
    idex_d.ex.alu_src = ALUSrc_i;
    idex_d.ex.branch  = Branch_i;
    idex_d.mem        = '{mem_read: MemRead_i, mem_write: MemWrite_i};
    idex_d.wb         = '{reg_write: RegWrite_i, mem_to_reg: MemtoReg_i};
    idex_d.rs1        = RS1addr_i;
    idex_d.rs2        = RS2addr_i;
    idex_d.rd         = RDaddr_i;
  end

  always_comb begin
    exmem_d     = '0;
    exmem_d.mem = idex_q.mem;
    exmem_d.wb  = idex_q.wb;
    exmem_d.rd  = idex_q.rd;
  end

  always_comb begin
    memwb_d    = '0;
    memwb_d.wb = exmem_q.wb;
    memwb_d.rd = exmem_q.rd;
  end

  // The bubble is forced here on hz itself, independent of whether the
  // decoder honours No_Op_o.
  ctrl_stage_reg #(.W($bits(idex_t))) u_idex (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (1'b1),
    .bubble_i (hz),
    .d_i      (idex_d),
    .q_o      (idex_q)
  );

  ctrl_stage_reg #(.W($bits(exmem_t))) u_exmem (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (1'b1),
    .bubble_i (1'b0),
    .d_i      (exmem_d),
    .q_o      (exmem_q)
  );

  ctrl_stage_reg #(.W($bits(memwb_t))) u_memwb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (1'b1),
    .bubble_i (1'b0),
    .d_i      (memwb_d),
    .q_o      (memwb_q)
  );

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                         input logic              mem_we,
                                         input logic [REG_AW-1:0] mem_rd,
                                         input logic              wb_we,
                                         input logic [REG_AW-1:0] wb_rd);
    logic [1:0] sel;
    sel = FWD_RF;
    if (mem_we && (mem_rd != '0) && (mem_rd == src)) begin
      sel = FWD_MEM;
    end else if (wb_we && (wb_rd != '0) && (wb_rd == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  assign ForwardA_o = fwd_sel(idex_q.rs1, exmem_q.wb.reg_write, exmem_q.rd,
                              memwb_q.wb.reg_write, memwb_q.rd);
  assign ForwardB_o = fwd_sel(idex_q.rs2, exmem_q.wb.reg_write, exmem_q.rd,
                              memwb_q.wb.reg_write, memwb_q.rd);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hz && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count_o = stall_cnt_q;

  assign EX_ALUOp_o     = idex_q.ex.alu_op;
  assign EX_ALUSrc_o    = idex_q.ex.alu_src;
  assign EX_RDaddr_o    = idex_q.rd;

  assign MEM_RegWrite_o = exmem_q.wb.reg_write;
  assign MEM_MemtoReg_o = exmem_q.wb.mem_to_reg;
  assign MEM_MemRead_o  = exmem_q.mem.mem_read;
  assign MEM_MemWrite_o = exmem_q.mem.mem_write;
  assign MEM_RDaddr_o   = exmem_q.rd;

  assign WB_RegWrite_o  = memwb_q.wb.reg_write;
  assign WB_MemtoReg_o  = memwb_q.wb.mem_to_reg;
  assign WB_RDaddr_o    = memwb_q.rd;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// tb_ctrl_pipeline: directed self-checking bench for ctrl_pipeline.
// A 2-bit stall counter is used so saturation is reached in a few stalls.
module tb_ctrl_pipeline;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 2;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [1:0]        ALUOp_i;
  logic              ALUSrc_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, Branch_i;
  logic [REG_AW-1:0] RS1addr_i, RS2addr_i, RDaddr_i;
  logic              No_Op_o, Stall_o, PCWrite_o;
  logic [1:0]        EX_ALUOp_o;
  logic              EX_ALUSrc_o;
  logic [REG_AW-1:0] EX_RDaddr_o;
  logic [1:0]        ForwardA_o, ForwardB_o;
  logic              MEM_RegWrite_o, MEM_MemtoReg_o, MEM_MemRead_o, MEM_MemWrite_o;
  logic [REG_AW-1:0] MEM_RDaddr_o;
  logic              WB_RegWrite_o, WB_MemtoReg_o;
  logic [REG_AW-1:0] WB_RDaddr_o;
  logic [CNT_W-1:0]  stall_count_o;

  int n_cmp = 0;
  int n_err = 0;

  ctrl_pipeline #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .ALUOp_i        (ALUOp_i),
    .ALUSrc_i       (ALUSrc_i),
    .RegWrite_i     (RegWrite_i),
    .MemtoReg_i     (MemtoReg_i),
    .MemRead_i      (MemRead_i),
    .MemWrite_i     (MemWrite_i),
    .Branch_i       (Branch_i),
    .RS1addr_i      (RS1addr_i),
    .RS2addr_i      (RS2addr_i),
    .RDaddr_i       (RDaddr_i),
    .No_Op_o        (No_Op_o),
    .Stall_o        (Stall_o),
    .PCWrite_o      (PCWrite_o),
    .EX_ALUOp_o     (EX_ALUOp_o),
    .EX_ALUSrc_o    (EX_ALUSrc_o),
    .EX_RDaddr_o    (EX_RDaddr_o),
    .ForwardA_o     (ForwardA_o),
    .ForwardB_o     (ForwardB_o),
    .MEM_RegWrite_o (MEM_RegWrite_o),
    .MEM_MemtoReg_o (MEM_MemtoReg_o),
    .MEM_MemRead_o  (MEM_MemRead_o),
    .MEM_MemWrite_o (MEM_MemWrite_o),
    .MEM_RDaddr_o   (MEM_RDaddr_o),
    .WB_RegWrite_o  (WB_RegWrite_o),
    .WB_MemtoReg_o  (WB_MemtoReg_o),
    .WB_RDaddr_o    (WB_RDaddr_o),
    .stall_count_o  (stall_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // aluop, alusrc, regwrite, memtoreg, memread, memwrite, branch, rs1, rs2, rd
  task automatic drive(input logic [1:0] aop, input logic asrc, input logic rw,
                       input logic m2r, input logic mr, input logic mw, input logic br,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    ALUOp_i = aop; ALUSrc_i = asrc; RegWrite_i = rw; MemtoReg_i = m2r;
    MemRead_i = mr; MemWrite_i = mw; Branch_i = br;
    RS1addr_i = rs1; RS2addr_i = rs2; RDaddr_i = rd;
    #1;
  endtask

  initial begin
    rst_i = 1'b1;
    drive(2'b00, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    #10;
    chk("rst_ex_rd",     32'(EX_RDaddr_o), 32'd0);
    chk("rst_wb_rw",     32'(WB_RegWrite_o), 32'd0);
    chk("rst_pcwrite",   32'(PCWrite_o), 32'd1);
    chk("rst_stall",     32'(Stall_o), 32'd0);
    chk("rst_fwd",       32'({ForwardA_o, ForwardB_o}), 32'd0);
    chk("rst_cnt",       32'(stall_count_o), 32'd0);
    rst_i = 1'b0;

    // R-type into x5, latency through the stages
    drive(2'b00, 0, 1, 0, 0, 0, 0, 5'd1, 5'd2, 5'd5);
    tick();
    chk("r_ex_rd",       32'(EX_RDaddr_o), 32'd5);
    chk("r_ex_aluop",    32'(EX_ALUOp_o), 32'd0);
    chk("r_pcwrite",     32'(PCWrite_o), 32'd1);
    drive(2'b00, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    tick();
    chk("r_mem_rd",      32'(MEM_RDaddr_o), 32'd5);
    chk("r_mem_rw",      32'(MEM_RegWrite_o), 32'd1);
    chk("r_pcwrite2",    32'(PCWrite_o), 32'd1);
    tick();
    chk("r_wb_rw",       32'(WB_RegWrite_o), 32'd1);
    chk("r_wb_rd",       32'(WB_RDaddr_o), 32'd5);
    chk("r_pcwrite3",    32'(PCWrite_o), 32'd1);

    // lw x3 followed by add x6, x3, x2
    drive(2'b01, 1, 1, 1, 1, 0, 0, 5'd1, 5'd0, 5'd3);
    tick();
    chk("ld_ex_alusrc",  32'(EX_ALUSrc_o), 32'd1);
    chk("ld_ex_aluop",   32'(EX_ALUOp_o), 32'd1);
    drive(2'b00, 0, 1, 0, 0, 0, 0, 5'd3, 5'd2, 5'd6);
    chk("lu_stall",      32'(Stall_o), 32'd1);
    chk("lu_noop",       32'(No_Op_o), 32'd1);
    chk("lu_pcwrite",    32'(PCWrite_o), 32'd0);
    tick();
    chk("lu_bub_rd",     32'(EX_RDaddr_o), 32'd0);
    chk("lu_bub_ctrl",   32'({EX_ALUOp_o, EX_ALUSrc_o}), 32'd0);
    chk("lu_cnt",        32'(stall_count_o), 32'd1);
    chk("lu_fwda_bub",   32'(ForwardA_o), 32'd0);
    chk("lu_mem_ld",     32'({MEM_MemRead_o, MEM_MemtoReg_o, MEM_RDaddr_o}), 32'h63);
    chk("lu_stall_drop", 32'(Stall_o), 32'd0);
    tick();
    chk("lu_add_ex",     32'(EX_RDaddr_o), 32'd6);
    chk("lu_fwda_wb",    32'(ForwardA_o), 32'd1);
    chk("lu_fwdb_rf",    32'(ForwardB_o), 32'd0);

    // ALU into x7, immediate use as rs2 -> MEM forward
    drive(2'b00, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd7);
    tick();
    drive(2'b00, 0, 0, 0, 0, 1, 0, 5'd0, 5'd7, 5'd8);
    tick();
    chk("alu_fwdb_mem",  32'(ForwardB_o), 32'd2);
    chk("alu_fwda_rf",   32'(ForwardA_o), 32'd0);

    // Same with one unrelated instruction in between -> WB forward
    drive(2'b00, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd7);
    tick();
    drive(2'b00, 0, 0, 0, 0, 0, 0, 5'd1, 5'd1, 5'd9);
    tick();
    drive(2'b00, 0, 0, 0, 0, 0, 0, 5'd0, 5'd7, 5'd8);
    tick();
    chk("gap_fwdb_wb",   32'(ForwardB_o), 32'd1);

    // x4 written in both MEM and WB -> MEM wins
    drive(2'b00, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd4);
    tick();
    tick();
    drive(2'b00, 0, 0, 0, 0, 0, 0, 5'd4, 5'd0, 5'd0);
    tick();
    chk("both_fwda_mem", 32'(ForwardA_o), 32'd2);

    // Load into x0, reader of x0 -> no stall, no forward
    drive(2'b01, 1, 1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    tick();
    drive(2'b00, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd10);
    chk("x0_stall",      32'(Stall_o), 32'd0);
    chk("x0_pcwrite",    32'(PCWrite_o), 32'd1);
    tick();
    chk("x0_fwd",        32'({ForwardA_o, ForwardB_o}), 32'd0);
    chk("x0_cnt",        32'(stall_count_o), 32'd1);

    // lw x3,0(x3) held in ID: stalls every other cycle until the counter saturates
    drive(2'b01, 1, 1, 1, 1, 0, 0, 5'd3, 5'd0, 5'd3);
    tick();
    chk("sat_hz1",       32'(Stall_o), 32'd1);
    tick();
    chk("sat_cnt2",      32'(stall_count_o), 32'd2);
    tick();
    tick();
    chk("sat_cnt3",      32'(stall_count_o), 32'd3);
    tick();
    chk("sat_hz3",       32'(Stall_o), 32'd1);
    tick();
    chk("sat_hold",      32'(stall_count_o), 32'd3);
    tick();
    chk("mid_hz",        32'(Stall_o), 32'd1);

    // Async reset in the middle of a stall
    rst_i = 1'b1;
    #1;
    chk("arst_stall",    32'({No_Op_o, Stall_o}), 32'd0);
    chk("arst_pcwrite",  32'(PCWrite_o), 32'd1);
    chk("arst_cnt",      32'(stall_count_o), 32'd0);
    chk("arst_ex",       32'({EX_ALUOp_o, EX_ALUSrc_o, EX_RDaddr_o}), 32'd0);
    chk("arst_mem",      32'({MEM_RegWrite_o, MEM_MemtoReg_o, MEM_MemRead_o, MEM_MemWrite_o, MEM_RDaddr_o}), 32'd0);
    chk("arst_wb",       32'({WB_RegWrite_o, WB_MemtoReg_o, WB_RDaddr_o}), 32'd0);
    chk("arst_fwd",      32'({ForwardA_o, ForwardB_o}), 32'd0);
    tick();
    rst_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
